// File: rtl/buffered_serial_transmitter_if.sv
// Write-side interface of buffered_serial_transmitter: push handshake plus FIFO status.
// The producer holds the master modport, the transmitter the slave modport.
interface buffered_serial_transmitter_if #(
  parameter int WORD_SIZE = 4,
  parameter int DEPTH     = 8
) ();
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  logic                 write_enable;
  logic [WORD_SIZE-1:0] data_in;
  logic                 clear_overflow;
  logic                 full;
  logic                 empty;
  logic [LEVEL_W-1:0]   level;
  logic                 overflow;

  modport master (
    output write_enable, data_in, clear_overflow,
    input  full, empty, level, overflow
  );

  modport slave (
    input  write_enable, data_in, clear_overflow,
    output full, empty, level, overflow
  );
endinterface

// File: rtl/buffered_serial_transmitter.sv
// FIFO-buffered UART-style framer: start bit, WORD_SIZE data bits LSB first, stop bit.
// Define BST_PARITY_EN to insert an even parity bit between the data and stop bits.
module buffered_serial_transmitter #(
  parameter int WORD_SIZE    = 4,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  buffered_serial_transmitter_if.slave wr,
  output logic                         busy,
  output logic                         tx
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = $clog2(DEPTH + 1);
  localparam int TMR_W   = $clog2(CLKS_PER_BIT);
  localparam int CNT_W   = $clog2(WORD_SIZE + 1);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);
  localparam logic [TMR_W-1:0]   LAST_TICK  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(WORD_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
`ifdef BST_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0]   level_q;
  logic                 overflow_q;
  logic                 full_w, empty_w, push, pop;

  state_t               state, state_d;
  logic [TMR_W-1:0]     timer, timer_d;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [WORD_SIZE-1:0] shift, shift_d;
  logic                 tx_d, bit_done;

`ifdef BST_PARITY_EN
  logic parity_q, parity_d;

  function automatic logic even_parity(input logic [WORD_SIZE-1:0] w);
    return ^w;
  endfunction
`endif

  assign full_w      = (level_q == FULL_LEVEL);
  assign empty_w     = (level_q == '0);
  assign push        = wr.write_enable && !full_w;
  assign pop         = (state == LOAD);
  assign wr.full     = full_w;
  assign wr.empty    = empty_w;
  assign wr.level    = level_q;
  assign wr.overflow = overflow_q;
  assign busy        = (state != IDLE);
  assign bit_done    = (timer == LAST_TICK);

  // FIFO control; full is the registered level, so a push while full drops even with a pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;
      if (wr.clear_overflow)                 overflow_q <= 1'b0;
      else if (wr.write_enable && full_w)    overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr.data_in;
  end

  // Framer state register; tx is registered from the next-state value so it leads by no cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      bit_cnt <= bit_cnt_d;
      tx      <= tx_d;
    end
  end

  always_ff @(posedge clock) begin
    shift    <= shift_d;
`ifdef BST_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
`ifdef BST_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state)
      IDLE: begin
        timer_d = '0;
        if (!empty_w) state_d = LOAD;
      end
      LOAD: begin
        shift_d   = mem[rd_ptr];
`ifdef BST_PARITY_EN
        parity_d  = even_parity(mem[rd_ptr]);
`endif
        timer_d   = '0;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        timer_d = timer + 1'b1;
        if (bit_done) begin
          timer_d = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        timer_d = timer + 1'b1;
        if (bit_done) begin
          timer_d = '0;
          shift_d = shift >> 1;
          if (bit_cnt == LAST_BIT) begin
`ifdef BST_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
`ifdef BST_PARITY_EN
      PARITY: begin
        timer_d = timer + 1'b1;
        if (bit_done) begin
          timer_d = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        timer_d = timer + 1'b1;
        if (bit_done) begin
          timer_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef BST_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_buffered_serial_transmitter.sv
// Bench for buffered_serial_transmitter (WORD_SIZE=4, DEPTH=4, CLKS_PER_BIT=4), honours BST_PARITY_EN.
// A frame-level queue model runs alongside every directed and random phase.
module tb_buffered_serial_transmitter;
  localparam int W   = 4;
  localparam int D   = 4;
  localparam int CPB = 4;
`ifdef BST_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (W + 2 + PAR) * CPB;
  localparam int LW    = $clog2(D + 1);

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic busy, tx;

  buffered_serial_transmitter_if #(.WORD_SIZE(W), .DEPTH(D)) bif ();

  buffered_serial_transmitter #(.WORD_SIZE(W), .DEPTH(D), .CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wr      (bif),
    .busy    (busy),
    .tx      (tx)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference: queue of accepted words, one word on the line at a time
  typedef enum {M_IDLE, M_LOAD, M_SEND} mphase_t;
  logic [W-1:0] mq[$];
  mphase_t      mphase = M_IDLE;
  int           mcnt   = 0;
  logic [W-1:0] mword  = '0;
  logic         movf   = 1'b0;
  bit           m_was_full, m_was_empty;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      mphase = M_IDLE;
      mcnt   = 0;
      movf   = 1'b0;
    end else begin
      m_was_full  = (mq.size() == D);
      m_was_empty = (mq.size() == 0);
      case (mphase)
        M_IDLE: if (!m_was_empty) mphase = M_LOAD;
        M_LOAD: begin
          mword  = mq.pop_front();
          mphase = M_SEND;
          mcnt   = 0;
        end
        default: if (mcnt == FRAME - 1) mphase = M_IDLE; else mcnt++;
      endcase
      if (bif.clear_overflow) movf = 1'b0;
      else if (bif.write_enable && m_was_full) movf = 1'b1;
      if (bif.write_enable && !m_was_full) mq.push_back(bif.data_in);
    end
  end

  function automatic logic model_tx();
    int idx;
    if (mphase != M_SEND) return 1'b1;
    idx = mcnt / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= W) return mword[idx-1];
    if (PAR == 1 && idx == W + 1) return ^mword;
    return 1'b1;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_tx", tx, model_tx());
      chk("model_busy", busy, mphase != M_IDLE);
      chk("model_level", bif.level, mq.size());
      chk("model_full", bif.full, mq.size() == D);
      chk("model_empty", bif.empty, mq.size() == 0);
      chk("model_overflow", bif.overflow, movf);
    end
  end

  task automatic frame_check(input logic [W-1:0] w, input logic [7:0] pat, input int nb);
    bif.write_enable = 1'b1;
    bif.data_in      = w;
    @(negedge clock);
    bif.write_enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("pre_start_tx", tx, 1'b1);
      @(negedge clock);
    end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("frame_bit%0d", b), tx, pat[b]);
        chk("busy_in_frame", busy, 1'b1);
        @(negedge clock);
      end
    end
    chk("after_frame_tx", tx, 1'b1);
    chk("after_frame_busy", busy, 1'b0);
    chk("after_frame_empty", bif.empty, 1'b1);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((busy || !bif.empty) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_drained"}, (busy || !bif.empty), 1'b0);
    chk({nm, "_tx_idle"}, tx, 1'b1);
  endtask

  typedef struct {
    logic          we;
    logic [W-1:0]  din;
    logic          clr;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          ovf;
    logic          busy;
  } vec_t;
  vec_t tbl[10];

  initial begin
    //               we  din   clr  full empty lvl  ovf busy
    tbl[0] = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1};

    bif.write_enable   = 1'b0;
    bif.data_in        = '0;
    bif.clear_overflow = 1'b0;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_empty", bif.empty, 1'b1);
    chk("reset_full", bif.full, 1'b0);
    chk("reset_level", bif.level, 0);
    chk("reset_overflow", bif.overflow, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single frames with hand-derived line patterns (bit i = i-th serial bit)
`ifdef BST_PARITY_EN
    frame_check(4'hA, 8'b0101_0100, 7);
    repeat (3) @(negedge clock);
    frame_check(4'h7, 8'b0110_1110, 7);
`else
    frame_check(4'hA, 8'b0011_0100, 6);
    repeat (3) @(negedge clock);
    frame_check(4'h5, 8'b0010_1010, 6);
`endif
    repeat (3) @(negedge clock);

    // Burst into idle block, overflow and clear_overflow priority
    for (int i = 0; i < 10; i++) begin
      bif.write_enable   = tbl[i].we;
      bif.data_in        = tbl[i].din;
      bif.clear_overflow = tbl[i].clr;
      @(negedge clock);
      chk($sformatf("tbl%0d_full", i), bif.full, tbl[i].full);
      chk($sformatf("tbl%0d_empty", i), bif.empty, tbl[i].empty);
      chk($sformatf("tbl%0d_level", i), bif.level, tbl[i].level);
      chk($sformatf("tbl%0d_overflow", i), bif.overflow, tbl[i].ovf);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
    end
    bif.write_enable   = 1'b0;
    bif.clear_overflow = 1'b0;
    wait_drain("burst");

    // Reset in the middle of the data bits with words still queued
    for (int i = 0; i < 3; i++) begin
      bif.write_enable = 1'b1;
      bif.data_in      = W'(i + 9);
      @(negedge clock);
    end
    bif.write_enable = 1'b0;
    repeat (CPB + 3) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_tx", tx, 1'b1);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_empty", bif.empty, 1'b1);
    chk("midreset_level", bif.level, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Randomized traffic with varying push density
    for (int seg = 0; seg < 6; seg++) begin
      int dens = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 12 : 40);
      for (int c = 0; c < 400; c++) begin
        bif.write_enable   = ($urandom_range(0, 99) < dens);
        bif.data_in        = W'($urandom);
        bif.clear_overflow = ($urandom_range(0, 15) == 0);
        @(negedge clock);
      end
    end
    bif.write_enable   = 1'b0;
    bif.clear_overflow = 1'b0;
    wait_drain("random");

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
